// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the sequential shift-add multiplier.
//   DEF_WIDTH  default operand/result width
//   CNT_W      iteration counter width for DEF_WIDTH
//   cnt_width  counter width helper for any WIDTH
//   state_t    controller states (IDLE, RUN)
package mult_pkg;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = $clog2(DEF_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mult_ctrl.sv
// mult_ctrl: handshake FSM and iteration counter for mult_unit.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   start     request, accepted only in IDLE
//   busy      registered, high for the WIDTH iteration edges
//   done      registered one-cycle pulse after the final iteration
//   load      combinational: this edge captures the operands
//   step      combinational: this edge performs one iteration
//   last      combinational: this edge performs the final iteration
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic load,
  output logic step,
  output logic last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t        state;
  logic [CW-1:0] count;

  // State, iteration counter and registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            count <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (count == LAST_CNT) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign load = (state == IDLE) && start;
  assign step = (state == RUN);
  assign last = (state == RUN) && (count == LAST_CNT);

endmodule

// File: rtl/mult_unit.sv
// mult_unit: sequential shift-add multiplier, WIDTH cycles per operation.
// Returns the low WIDTH bits of OP1*OP2 (valid for signed and unsigned).
// Ports:
//   CLK, RESET  clock and asynchronous active-high reset
//   START       request, sampled while BUSY=0
//   OP1, OP2    multiplicand and multiplier (two's complement)
//   RESULT      registered low WIDTH bits of the product
//   BUSY        high while an operation is in progress
//   DONE        one-cycle pulse when RESULT is updated
//   OVERFLOW    signed product does not fit in WIDTH bits
//               (only present when MULT_OVF_EN is defined)
// Build option: MULT_OVF_EN adds the OVERFLOW output and keeps the full
// 2*WIDTH accumulator; without it the accumulator is WIDTH bits wide.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
`ifdef MULT_OVF_EN
  output logic             OVERFLOW,
`endif
  output logic             DONE
);

`ifdef MULT_OVF_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif

  logic             load;
  logic             step;
  logic             last;

  logic [ACC_W-1:0] mcand;     // sign-extended multiplicand, shifted left each step
  logic [WIDTH-1:0] mplier;    // multiplier, shifted right so bit 0 is the current bit
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] acc_next;

  mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk   (CLK),
    .rst   (RESET),
    .start (START),
    .busy  (BUSY),
    .done  (DONE),
    .load  (load),
    .step  (step),
    .last  (last)
  );

  // Partial product for the current bit; the MSB has negative weight.
  always_comb begin
    term     = '0;
    acc_next = acc;
    if (mplier[0]) begin
      term = mcand;
    end else begin
      term = '0;
    end
    if (last) begin
      acc_next = acc - term;
    end else begin
      acc_next = acc + term;
    end
  end

`ifdef MULT_OVF_EN
  logic [WIDTH:0] upper;
  logic           ovf;

  // Product fits iff the sign bit and everything above it agree.
  always_comb begin
    upper = acc_next[2*WIDTH-1:WIDTH-1];
    ovf   = !((&upper) || (~|upper));
  end
`endif

  // Operand capture, accumulation and result register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      RESULT   <= '0;
`ifdef MULT_OVF_EN
      OVERFLOW <= 1'b0;
`endif
    end else if (load) begin
      mcand  <= ACC_W'($signed(OP1));
      mplier <= OP2;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (last) begin
        RESULT   <= acc_next[WIDTH-1:0];
`ifdef MULT_OVF_EN
        OVERFLOW <= ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed self-checking bench for mult_unit (WIDTH=8).
// Inputs change on the falling edge; outputs are sampled 1ns after the
// rising edge. OVERFLOW is checked only when MULT_OVF_EN is defined.
module tb_mult_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [7:0] OP1;
  logic [7:0] OP2;
  logic [7:0] RESULT;
  logic       BUSY;
  logic       DONE;
`ifdef MULT_OVF_EN
  logic       OVERFLOW;
`endif

  int checks   = 0;
  int failures = 0;

  mult_unit #(.WIDTH(8)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .OP1      (OP1),
    .OP2      (OP2),
    .RESULT   (RESULT),
    .BUSY     (BUSY),
`ifdef MULT_OVF_EN
    .OVERFLOW (OVERFLOW),
`endif
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for DONE after the current edge; lat = edges waited, held = RESULT
  // stayed unchanged until the completion edge.
  task automatic wait_done(output int lat, output logic held);
    logic [7:0] prev;
    prev = RESULT;
    held = 1'b1;
    lat  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      lat++;
      if (DONE) break;
      if (RESULT !== prev) held = 1'b0;
    end
    if (!DONE) lat = 99;
  endtask

  // Single operation started from idle; checks latency, result, pulse width.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input logic exp_ovf);
    int   lat;
    logic held;
    @(negedge CLK);
    OP1   = a;
    OP2   = b;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    check({tag, "_busy"}, BUSY, 1'b1);
    wait_done(lat, held);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_res"}, RESULT, exp);
    check({tag, "_hold"}, held, 1'b1);
    check({tag, "_busy_at_done"}, BUSY, 1'b0);
`ifdef MULT_OVF_EN
    check({tag, "_ovf"}, OVERFLOW, exp_ovf);
`else
    if (exp_ovf === 1'bx) check({tag, "_ovf_arg"}, exp_ovf, 1'b0);
`endif
    @(posedge CLK);
    #1;
    check({tag, "_done_pulse"}, DONE, 1'b0);
  endtask

  initial begin
    int   lat;
    logic held;
    int   dones;

    RESET = 1'b1;
    START = 1'b0;
    OP1   = 8'd0;
    OP2   = 8'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_result", RESULT, 8'd0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;

    // Unsigned
    run_op("u3x1", 8'd3, 8'd1, 8'd3, 1'b0);
    run_op("u5x7", 8'd5, 8'd7, 8'd35, 1'b0);

    // Asynchronous reset in the middle of a 3*5 run
    @(negedge CLK);
    OP1   = 8'd3;
    OP2   = 8'd5;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("midrst_result", RESULT, 8'd0);
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_done", DONE, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge CLK);
      #1;
      if (DONE) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_idle", BUSY, 1'b0);

    // Signed
    run_op("sm3x7", 8'hFD, 8'd7, 8'hEB, 1'b0);
    run_op("sm8xm8", 8'hF8, 8'hF8, 8'h40, 1'b0);

    // Wrap and overflow
    run_op("w16x16", 8'd16, 8'd16, 8'h00, 1'b1);
    run_op("wm128x1", 8'h80, 8'd1, 8'h80, 1'b0);
    run_op("wm128xm1", 8'h80, 8'hFF, 8'h80, 1'b1);

    // START held through RUN with operands changed mid-op
    @(negedge CLK);
    OP1   = 8'd2;
    OP2   = 8'd6;
    START = 1'b1;
    @(posedge CLK);
    #1;
    repeat (3) @(posedge CLK);
    #1;
    OP1 = 8'd9;
    OP2 = 8'd9;
    check("hs_busy_mid", BUSY, 1'b1);
    wait_done(lat, held);
    check("hs_first_lat", lat, 5);
    check("hs_first_res", RESULT, 8'd12);
    check("hs_first_busy", BUSY, 1'b0);
    @(posedge CLK);
    #1;
    check("hs_accept_k9", BUSY, 1'b1);
    check("hs_done_pulse", DONE, 1'b0);
    START = 1'b0;
    wait_done(lat, held);
    check("hs_second_lat", lat, 8);
    check("hs_second_res", RESULT, 8'd81);
    check("hs_second_hold", held, 1'b1);

    // Zero operand, full latency
    run_op("zero", 8'd0, 8'hFF, 8'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
